// File: rtl/sram_arbiter.sv
// Arbitrates one external async SRAM between video (read-only), CPU and DMA ports.
// One fixed-length access at a time: IDLE -> ACCESS (ACC_CYCLES) -> DONE -> IDLE.
module sram_arbiter #(
   parameter int AW           = 19,
   parameter int DW           = 8,
   parameter int ACC_CYCLES   = 2,
   parameter int DMA_MAX_WAIT = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [DW-1:0] vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] sram_addr,
   inout  wire  [DW-1:0] sram_data,
   output logic          sram_we_n,
   output logic          busy,
   output logic [1:0]    owner
);

   localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam int WW = (DMA_MAX_WAIT > 1) ? $clog2(DMA_MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(DMA_MAX_WAIT);
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_VID  = 2'b01;
   localparam logic [1:0] OWN_CPU  = 2'b10;
   localparam logic [1:0] OWN_DMA  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic [1:0]    owner_q, owner_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [DW-1:0] vid_rdata_q, cpu_rdata_q, dma_rdata_q;
   logic          dma_first;
   logic          wr_act;
   logic          rd_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         owner_q <= OWN_NONE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         owner_q <= owner_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      owner_d   = owner_q;
      wait_d    = wait_q;
      // An aged DMA request jumps ahead of the CPU, never ahead of video.
      dma_first = (wait_q == WAIT_MAX) || !cpu_req;
      case (state_q)
         S_IDLE: begin
            if (vid_req || cpu_req || dma_req) begin
               state_d = S_ACCESS;
               cnt_d   = '0;
            end
            if (vid_req) begin
               addr_d  = vid_addr;
               wdata_d = '0;
               we_d    = 1'b0;
               owner_d = OWN_VID;
            end else if (dma_req && dma_first) begin
               addr_d  = dma_addr;
               wdata_d = dma_wdata;
               we_d    = dma_we;
               owner_d = OWN_DMA;
            end else if (cpu_req) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               we_d    = cpu_we;
               owner_d = OWN_CPU;
            end
            if (dma_req) begin
               if (!vid_req && dma_first) wait_d = '0;
               else if (wait_q != WAIT_MAX) wait_d = wait_q + WW'(1);
            end
         end
         S_ACCESS: begin
            if (cnt_q == CNT_LAST) state_d = S_DONE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_act  = (state_q == S_ACCESS) && we_q;
   assign rd_last = (state_q == S_ACCESS) && (cnt_q == CNT_LAST) && !we_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid_rdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else if (rd_last) begin
         case (owner_q)
            OWN_VID: vid_rdata_q <= sram_data;
            OWN_CPU: cpu_rdata_q <= sram_data;
            OWN_DMA: dma_rdata_q <= sram_data;
            default: ;
         endcase
      end
   end

   // Write strobe skips ACCESS cycle 0 so address and data settle around the pulse.
   assign sram_we_n = !(wr_act && (cnt_q != '0));
   assign sram_data = wr_act ? wdata_q : {DW{1'bz}};
   assign sram_addr = addr_q;

   assign vid_ack   = (state_q == S_DONE) && (owner_q == OWN_VID);
   assign cpu_ack   = (state_q == S_DONE) && (owner_q == OWN_CPU);
   assign dma_ack   = (state_q == S_DONE) && (owner_q == OWN_DMA);
   assign vid_rdata = vid_rdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign busy      = (state_q != S_IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the shared bus, transaction table plus
// hand-written corner sequences, expected acks tracked in a scoreboard queue.
module tb_sram_arbiter;
   localparam int AW  = 19;
   localparam int DW  = 8;
   localparam int ACC = 2;
   localparam int MW  = 3;
   localparam int TO  = 40;
   localparam logic [DW-1:0] PROBE = 8'hC3;

   typedef struct {
      logic [1:0]    port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
   logic          cpu_we = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
   logic          vid_ack, cpu_ack, dma_ack;
   logic [DW-1:0] vid_rdata, cpu_rdata, dma_rdata;
   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_data;
   logic          sram_we_n, busy;
   logic [1:0]    owner;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] shadow [4];
   logic [DW-1:0] tb_val;
   logic          write_phase, read_phase;
   vec_t          sb[$];
   vec_t          tbl[11];
   vec_t          mon_e;
   int            n_chk = 0, n_fail = 0, cyc = 0, ack_seen = 0, we_low_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   sram_arbiter #(.AW(AW), .DW(DW), .ACC_CYCLES(ACC), .DMA_MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n),
      .busy(busy), .owner(owner)
   );

   // SRAM model: releases the bus during write accesses, otherwise drives read data or a probe pattern.
   assign write_phase = ((owner == 2'b10 && cpu_we) || (owner == 2'b11 && dma_we)) && !cpu_ack && !dma_ack;
   assign read_phase  = (owner == 2'b01) || (owner == 2'b10 && !cpu_we) || (owner == 2'b11 && !dma_we);
   always_comb begin
      tb_val = PROBE;
      if (read_phase) tb_val = mem[sram_addr];
   end
   assign sram_data = write_phase ? {DW{1'bz}} : tb_val;

   always @(negedge clk) if (!sram_we_n) mem[sram_addr] = sram_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] onehot(input logic [1:0] p);
      case (p)
         2'd1:    return 3'b100;
         2'd2:    return 3'b010;
         2'd3:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if ({vid_ack, cpu_ack, dma_ack} != 3'b000) begin
            ack_seen++;
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("ack_port", 32'({vid_ack, cpu_ack, dma_ack}), 32'(onehot(mon_e.port)));
               chk("owner_at_ack", 32'(owner), 32'(mon_e.port));
               if (mon_e.we) begin
                  chk("we_pulse_cycles", 32'(we_low_cnt), 32'(ACC - 1));
                  we_low_cnt = 0;
               end else begin
                  shadow[mon_e.port] = mon_e.exp;
               end
               chk("vid_rdata", 32'(vid_rdata), 32'(shadow[1]));
               chk("cpu_rdata", 32'(cpu_rdata), 32'(shadow[2]));
               chk("dma_rdata", 32'(dma_rdata), 32'(shadow[3]));
            end
         end
         if (write_phase && sb.size() != 0) begin
            chk("wr_addr_stable", 32'(sram_addr), 32'(sb[0].addr));
            chk("wr_data_stable", 32'(sram_data), 32'(sb[0].wdata));
            if (!sram_we_n) we_low_cnt++;
         end
         if (read_phase) chk("rd_we_n_high", 32'(sram_we_n), 32'd1);
      end
   end

   task automatic set_port(input logic [1:0] p, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      case (p)
         2'd1: begin vid_req = req; vid_addr = a; end
         2'd2: begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
         2'd3: begin dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; end
         default: ;
      endcase
   endtask

   task automatic wait_acks(input int target);
      int n = 0;
      while (ack_seen < target && n < TO) begin
         @(negedge clk); #1;
         n++;
      end
      if (ack_seen < target) chk("ack_timeout", 32'(ack_seen), 32'(target));
   endtask

   task automatic do_txn(input vec_t v);
      int c0, s0;
      s0 = ack_seen;
      set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
      sb.push_back(v);
      c0 = cyc;
      wait_acks(s0 + 1);
      if (ack_seen > s0) chk("latency", 32'(cyc - c0), 32'(ACC + 1));
      @(posedge clk); #1;
      set_port(v.port, 1'b0, 1'b0, '0, '0);
      if (v.we) chk("mem_write", 32'(mem[v.addr]), 32'(v.wdata));
   endtask

   initial begin
      int s0, t1, t2;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'h3C;
      mem[19'h12345] = 8'hA5;
      mem[19'h00000] = 8'h11;
      for (int i = 0; i < 4; i++) shadow[i] = '0;

      //          port  we    addr        wdata  exp
      tbl[0]  = '{2'd2, 1'b0, 19'h12345, 8'h00, 8'hA5};
      tbl[1]  = '{2'd2, 1'b1, 19'h00100, 8'h5A, 8'h00};
      tbl[2]  = '{2'd2, 1'b0, 19'h00100, 8'h00, 8'h5A};
      tbl[3]  = '{2'd3, 1'b1, 19'h7FFFF, 8'hC7, 8'h00};
      tbl[4]  = '{2'd3, 1'b0, 19'h7FFFF, 8'h00, 8'hC7};
      tbl[5]  = '{2'd1, 1'b0, 19'h7FFFF, 8'h00, 8'hC7};
      tbl[6]  = '{2'd1, 1'b0, 19'h00000, 8'h00, 8'h11};
      tbl[7]  = '{2'd3, 1'b0, 19'h00100, 8'h00, 8'h5A};
      tbl[8]  = '{2'd2, 1'b1, 19'h7FFFF, 8'h00, 8'h00};
      tbl[9]  = '{2'd1, 1'b0, 19'h7FFFF, 8'h00, 8'h00};
      tbl[10] = '{2'd2, 1'b0, 19'h12345, 8'h00, 8'hA5};

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_data_released", 32'(sram_data), 32'(PROBE));
      chk("rst_acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_rdata", 32'({vid_rdata, cpu_rdata, dma_rdata}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) do_txn(tbl[i]);

      // Video and CPU requesting together: video first, CPU one access period later.
      s0 = ack_seen;
      sb.push_back('{2'd1, 1'b0, 19'h00000, 8'h00, 8'h11});
      sb.push_back('{2'd2, 1'b0, 19'h12345, 8'h00, 8'hA5});
      set_port(2'd1, 1'b1, 1'b0, 19'h00000, 8'h00);
      set_port(2'd2, 1'b1, 1'b0, 19'h12345, 8'h00);
      wait_acks(s0 + 1);
      t1 = cyc;
      @(posedge clk); #1;
      set_port(2'd1, 1'b0, 1'b0, '0, '0);
      wait_acks(s0 + 2);
      t2 = cyc;
      chk("b2b_gap", 32'(t2 - t1), 32'(ACC + 2));
      @(posedge clk); #1;
      set_port(2'd2, 1'b0, 1'b0, '0, '0);

      // CPU and DMA held high: DMA gets in after MW lost arbitrations, then ages again.
      s0 = ack_seen;
      for (int i = 0; i < 9; i++) begin
         if (i == 3 || i == 7) sb.push_back('{2'd3, 1'b0, 19'h00000, 8'h00, 8'h11});
         else                  sb.push_back('{2'd2, 1'b0, 19'h12345, 8'h00, 8'hA5});
      end
      set_port(2'd2, 1'b1, 1'b0, 19'h12345, 8'h00);
      set_port(2'd3, 1'b1, 1'b0, 19'h00000, 8'h00);
      wait_acks(s0 + 9);
      @(posedge clk); #1;
      set_port(2'd2, 1'b0, 1'b0, '0, '0);
      set_port(2'd3, 1'b0, 1'b0, '0, '0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      // Reset asserted while the write strobe is low.
      @(posedge clk); #1;
      set_port(2'd2, 1'b1, 1'b1, 19'h00200, 8'h99);
      @(posedge clk);
      @(posedge clk);
      #1 chk("we_low_before_rst", 32'(sram_we_n), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_data_released", 32'(sram_data), 32'(PROBE));
      chk("abort_owner", 32'(owner), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
      set_port(2'd2, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 4; i++) shadow[i] = '0;
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mem_unchanged", 32'(mem[19'h00200]), 32'h3C);
      @(posedge clk); #1;
      do_txn(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
